// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_multi
//  Purpose  : Multi-channel programmable clock divider. Each channel has a
//             runtime-writable divide ratio N = div+1 (1..2^WIDTH), its own
//             count enable, a one-cycle tick strobe and a near-50% duty
//             divided square wave. A global sync restarts all channels
//             phase-aligned.
//  Ports    :
//     clk      in   system clock, rising edge
//     reset_n  in   asynchronous active-low reset
//     wr_en    in   divisor write strobe
//     wr_addr  in   [ADDR_WIDTH-1:0] channel index for the write
//     wr_data  in   [WIDTH-1:0] new divisor (ratio = wr_data+1)
//     enable   in   [CHANNELS-1:0] per-channel count enable
//     sync     in   synchronous restart of all channel counters
//     tick     out  [CHANNELS-1:0] one-cycle strobe every N enabled cycles
//     divclk   out  [CHANNELS-1:0] divided square wave
//  Revision : 1.0  initial release
// ============================================================================
module clock_divider_multi #(
   parameter int WIDTH      = 16,
   parameter int CHANNELS   = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [CHANNELS-1:0]   enable,
   input  logic                  sync,
   output logic [CHANNELS-1:0]   tick,
   output logic [CHANNELS-1:0]   divclk
);

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
         // Only indices below CHANNELS have a decoder here, so writes to
         // out-of-range addresses simply match nothing.
         localparam logic [ADDR_WIDTH-1:0] c_idx = ADDR_WIDTH'(c);

         logic [WIDTH-1:0] r_div;
         logic [WIDTH-1:0] r_cnt;
         logic             r_tick;
         logic             r_divclk;
         logic             w_wr_hit;
         logic             w_wrap;
         logic             w_high;

         assign w_wr_hit = wr_en && (wr_addr == c_idx);
         // >= rather than == so that shrinking div below the current count
         // wraps on the next enabled edge instead of running to 2^WIDTH.
         assign w_wrap   = (r_cnt >= r_div);
         // High for cnt = 0..floor(div/2): ceil(N/2) of every N cycles.
         assign w_high   = (r_cnt <= (r_div >> 1));

         // Divisor register: independent of sync/enable, so a write in the
         // same cycle as sync still lands.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_div <= '0;
            end else if (w_wr_hit) begin
               r_div <= wr_data;
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt    <= '0;
               r_tick   <= 1'b0;
               r_divclk <= 1'b0;
            end else if (sync) begin
               r_cnt    <= '0;
               r_tick   <= 1'b0;
               r_divclk <= 1'b0;
            end else if (enable[c]) begin
               r_cnt    <= w_wrap ? '0 : r_cnt + WIDTH'(1);
               r_tick   <= w_wrap;
               r_divclk <= w_high;
            end else begin
               // Paused: square wave and count freeze, strobe drops.
               r_tick   <= 1'b0;
            end
         end

         assign tick[c]   = r_tick;
         assign divclk[c] = r_divclk;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_divider_multi
//  Purpose  : Directed self-checking bench for clock_divider_multi
//             (WIDTH=8, CHANNELS=4, ADDR_WIDTH=3 so that addresses 4..7
//             are out of range).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clock_divider_multi;

   localparam int WIDTH      = 8;
   localparam int CHANNELS   = 4;
   localparam int ADDR_WIDTH = 3;

   logic                  clk     = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  wr_en   = 1'b0;
   logic [ADDR_WIDTH-1:0] wr_addr = '0;
   logic [WIDTH-1:0]      wr_data = '0;
   logic [CHANNELS-1:0]   enable  = '0;
   logic                  sync    = 1'b0;
   logic [CHANNELS-1:0]   tick;
   logic [CHANNELS-1:0]   divclk;

   // reference state
   logic [WIDTH-1:0]    m_div [CHANNELS];
   logic [WIDTH-1:0]    m_cnt [CHANNELS];
   logic [CHANNELS-1:0] m_tick;
   logic [CHANNELS-1:0] m_divclk;

   int n_vec = 0;
   int n_err = 0;

   clock_divider_multi #(
      .WIDTH      (WIDTH),
      .CHANNELS   (CHANNELS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .enable  (enable),
      .sync    (sync),
      .tick    (tick),
      .divclk  (divclk)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CHANNELS; c++) begin
         m_div[c] = '0;
         m_cnt[c] = '0;
      end
      m_tick   = '0;
      m_divclk = '0;
   endtask

   // One rising edge of the reference: count with the old divisor, then write.
   task automatic model_edge();
      for (int c = 0; c < CHANNELS; c++) begin
         if (sync) begin
            m_cnt[c]    = '0;
            m_tick[c]   = 1'b0;
            m_divclk[c] = 1'b0;
         end else if (enable[c]) begin
            m_tick[c]   = (m_cnt[c] >= m_div[c]);
            m_divclk[c] = (m_cnt[c] <= (m_div[c] >> 1));
            m_cnt[c]    = m_tick[c] ? '0 : m_cnt[c] + 8'd1;
         end else begin
            m_tick[c] = 1'b0;
         end
      end
      if (wr_en && (wr_addr < CHANNELS)) m_div[wr_addr[1:0]] = wr_data;
   endtask

   // Advance one clock, then compare both output vectors at the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("tick", 32'(tick), 32'(m_tick));
      chk("divclk", 32'(divclk), 32'(m_divclk));
   endtask

   task automatic write(input int addr, input int data);
      wr_en   = 1'b1;
      wr_addr = ADDR_WIDTH'(addr);
      wr_data = WIDTH'(data);
      cycle();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      cycle();
      sync = 1'b0;
   endtask

   initial begin
      int n_ticks;
      int last;
      model_reset();

      // ---- reset and idle
      repeat (3) @(negedge clk);
      chk("rst_tick", 32'(tick), 0);
      chk("rst_divclk", 32'(divclk), 0);
      reset_n = 1'b1;
      repeat (10) cycle();

      // ---- ratio 1 and 2
      write(0, 0);
      write(1, 1);
      write(2, 3);
      write(3, 4);
      enable = 4'b0011;
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("n1_tick", 32'(tick[0]), 1);
         chk("n1_divclk", 32'(divclk[0]), 1);
         chk("n2_tick", 32'(tick[1]), 32'(i % 2));
         chk("n2_divclk", 32'(divclk[1]), 32'(i % 2 == 0));
      end

      // ---- N=4 and N=5
      enable = 4'b1100;
      for (int i = 0; i < 40; i++) begin
         cycle();
         chk("n4_tick", 32'(tick[2]), 32'(i % 4 == 3));
         chk("n4_divclk", 32'(divclk[2]), 32'(i % 4 < 2));
         chk("n5_tick", 32'(tick[3]), 32'(i % 5 == 4));
         chk("n5_divclk", 32'(divclk[3]), 32'(i % 5 < 3));
      end

      // ---- divisor shrunk below current count
      enable = '0;
      pulse_sync();
      write(0, 9);
      enable = 4'b0001;
      repeat (7) cycle();
      enable = '0;
      write(0, 2);
      enable = 4'b0001;
      for (int i = 0; i < 7; i++) begin
         cycle();
         chk("shrink_tick", 32'(tick[0]), 32'(i % 3 == 0));
         chk("shrink_divclk", 32'(divclk[0]), (i == 0) ? 0 : 32'((i - 1) % 3 < 2));
      end

      // ---- out-of-range writes leave every divisor alone
      enable = '0;
      write(4, 0);
      write(7, 0);
      enable = 4'b1111;
      n_ticks = 0;
      repeat (6) begin
         cycle();
         if (tick[0]) n_ticks++;
      end
      chk("oor_ch0_ticks", 32'(n_ticks), 2);

      // ---- enable gating
      enable = '0;
      pulse_sync();
      enable = 4'b0100;
      repeat (2) begin
         cycle();
         chk("gate_run_divclk", 32'(divclk[2]), 1);
      end
      enable = '0;
      repeat (5) begin
         cycle();
         chk("gate_hold_divclk", 32'(divclk[2]), 1);
         chk("gate_hold_tick", 32'(tick[2]), 0);
      end
      enable = 4'b0100;
      cycle();
      chk("gate_resume1_tick", 32'(tick[2]), 0);
      cycle();
      chk("gate_resume2_tick", 32'(tick[2]), 1);

      // ---- sync with channels at differing phases, write in same cycle
      enable = 4'b1111;
      repeat (5) cycle();
      sync = 1'b1;
      write(1, 5);
      sync = 1'b0;
      chk("sync_tick", 32'(tick), 0);
      chk("sync_divclk", 32'(divclk), 0);
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (i == 5)  chk("sync_wr_ch1_tick", 32'(tick[1]), 1);
         if (i == 59) chk("aligned_tick", 32'(tick), 32'hF);
      end

      // ---- full-range ratio 256
      enable = '0;
      write(0, 255);
      pulse_sync();
      enable  = 4'b0001;
      n_ticks = 0;
      last    = -1;
      for (int i = 0; i < 2000; i++) begin
         cycle();
         if (tick[0]) begin
            n_ticks++;
            if (last < 0) chk("first_tick_edge", 32'(i), 255);
            else          chk("tick_spacing", 32'(i - last), 256);
            last = i;
         end
      end
      chk("tick_count", 32'(n_ticks), 7);
      pulse_sync();
      chk("post_sync_tick", 32'(tick[0]), 0);
      chk("post_sync_divclk", 32'(divclk[0]), 0);

      // ---- asynchronous reset mid-count
      repeat (3) cycle();
      chk("pre_rst_divclk", 32'(divclk[0]), 1);
      @(posedge clk);
      model_edge();
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_tick", 32'(tick), 0);
      chk("async_rst_divclk", 32'(divclk), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cycle();
      chk("post_rst_div_cleared", 32'(tick[0]), 1);
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
